// File: rtl/single_frame_drive_pkg.sv
// Shared constants for the AXI4-Lite frame source: register word offsets,
// field bit positions, response codes and the serializer state encoding.
package single_frame_drive_pkg;

    localparam logic [8:0] CTRL_IDX   = 9'h1FC;  // byte 0x7F0
    localparam logic [8:0] STATUS_IDX = 9'h1FD;  // byte 0x7F4
    localparam logic [8:0] DIV_IDX    = 9'h1FE;  // byte 0x7F8

    localparam int CTRL_COMMIT_BIT    = 0;
    localparam int CTRL_SER_EN_BIT    = 1;
    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_OVERRUN_BIT = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/single_frame_drive_if.sv
// AXI4-Lite slave channel bundle for single_frame_drive.
// Each channel transfers on a rising edge where its VALID and READY are both high.
interface single_frame_drive_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

endinterface

// File: rtl/frame_serializer.sv
// Shifts a latched frame out LSB-first, each bit held for div+1 cycles.
// The frame and divider are captured on load so later register writes cannot disturb a transfer.
module frame_serializer
    import single_frame_drive_pkg::*;
#(
    parameter int FRAME_WIDTH = 256
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_load,
    input  logic [FRAME_WIDTH-1:0] i_frame,
    input  logic [15:0]            i_div,
    output logic                   o_ser_data,
    output logic                   o_ser_valid,
    output logic                   o_ser_done,
    output logic                   o_busy,
    output ser_state_e             o_state
);
    localparam int BIT_W = $clog2(FRAME_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_WIDTH - 1);

    ser_state_e             r_state;
    logic [FRAME_WIDTH-1:0] r_shift;
    logic [15:0]            r_div;
    logic [15:0]            r_div_cnt;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic                   r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_div     <= '0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_load) begin
                        r_state   <= ST_SHIFT;
                        r_shift   <= i_frame;
                        r_div     <= i_div;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (r_div_cnt == r_div) begin
                        // Zero fill leaves ser_data low once the last bit is gone.
                        r_div_cnt <= '0;
                        r_shift   <= {1'b0, r_shift[FRAME_WIDTH-1:1]};
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ser_data  = r_shift[0];
    assign o_ser_valid = (r_state == ST_SHIFT);
    assign o_busy      = (r_state == ST_SHIFT);
    assign o_ser_done  = r_done;
    assign o_state     = r_state;

endmodule

// File: rtl/single_frame_drive.sv
// AXI4-Lite programmed frame source: shadow buffer, atomic commit to frame_out,
// optional LSB-first serial transfer, and CTRL/STATUS/DIV registers.
module single_frame_drive
    import single_frame_drive_pkg::*;
#(
    parameter int FRAME_WIDTH        = 256,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 11
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESETN,
    single_frame_drive_if.slave    s_axi,
    output logic [FRAME_WIDTH-1:0] frame_out,
    output logic                   frame_valid,
    output logic                   ser_data,
    output logic                   ser_valid,
    output logic                   ser_done
);
    localparam int NWORDS = FRAME_WIDTH / 32;
    localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;

    logic [FRAME_WIDTH-1:0]        r_shadow, r_active;
    logic                          r_frame_valid, r_ser_en, r_overrun;
    logic [15:0]                   r_div, r_count;
    logic                          r_bvalid, r_rvalid;
    logic [1:0]                    r_bresp, r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    logic [IDX_W-1:0]              w_aw_idx, w_ar_idx;
    logic                          w_wr_acc, w_rd_acc, w_aw_mapped;
    logic                          w_ser_en_next, w_commit_req, w_commit, w_overrun_set;
    logic                          w_busy, w_shift_active;
    ser_state_e                    w_ser_state;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]                    w_rd_resp;
    logic                          w_unused;

    assign w_aw_idx = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_ar_idx = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    // Ready is held low in reset so nothing is accepted while ARESETN is asserted.
    assign w_wr_acc = S_AXI_ARESETN & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~r_bvalid;
    assign w_rd_acc = S_AXI_ARESETN & s_axi.S_AXI_ARVALID & ~r_rvalid;

    assign w_aw_mapped = (int'(w_aw_idx) < NWORDS) || (w_aw_idx == CTRL_IDX) ||
                         (w_aw_idx == STATUS_IDX)  || (w_aw_idx == DIV_IDX);

    // A CTRL write carrying both SER_EN and COMMIT uses the SER_EN being written.
    assign w_ser_en_next  = (w_aw_idx == CTRL_IDX && s_axi.S_AXI_WSTRB[0]) ?
                            s_axi.S_AXI_WDATA[CTRL_SER_EN_BIT] : r_ser_en;
    assign w_shift_active = (w_ser_state == ST_SHIFT);
    assign w_commit_req   = w_wr_acc && (w_aw_idx == CTRL_IDX) && s_axi.S_AXI_WSTRB[0] &&
                            s_axi.S_AXI_WDATA[CTRL_COMMIT_BIT];
    assign w_commit       = w_commit_req & ~w_shift_active;
    assign w_overrun_set  = w_commit_req &  w_shift_active;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_shadow      <= '0;
            r_active      <= '0;
            r_frame_valid <= 1'b0;
            r_ser_en      <= 1'b0;
            r_overrun     <= 1'b0;
            r_div         <= '0;
            r_count       <= '0;
            r_bvalid      <= 1'b0;
            r_bresp       <= RESP_OKAY;
        end else begin
            r_frame_valid <= w_commit;
            if (w_commit) begin
                r_active <= r_shadow;
                r_count  <= r_count + 16'd1;
            end
            if (w_overrun_set)
                r_overrun <= 1'b1;
            else if (w_wr_acc && w_aw_idx == STATUS_IDX && s_axi.S_AXI_WSTRB[0] &&
                     s_axi.S_AXI_WDATA[STATUS_OVERRUN_BIT])
                r_overrun <= 1'b0;
            if (w_wr_acc) begin
                for (int i = 0; i < NWORDS; i++)
                    if (int'(w_aw_idx) == i)
                        for (int b = 0; b < 4; b++)
                            if (s_axi.S_AXI_WSTRB[b])
                                r_shadow[i*32 + b*8 +: 8] <= s_axi.S_AXI_WDATA[b*8 +: 8];
                if (w_aw_idx == CTRL_IDX && s_axi.S_AXI_WSTRB[0])
                    r_ser_en <= s_axi.S_AXI_WDATA[CTRL_SER_EN_BIT];
                if (w_aw_idx == DIV_IDX) begin
                    if (s_axi.S_AXI_WSTRB[0]) r_div[7:0]  <= s_axi.S_AXI_WDATA[7:0];
                    if (s_axi.S_AXI_WSTRB[1]) r_div[15:8] <= s_axi.S_AXI_WDATA[15:8];
                end
                r_bvalid <= 1'b1;
                r_bresp  <= w_aw_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (r_bvalid && s_axi.S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        if (int'(w_ar_idx) < NWORDS) begin
            for (int i = 0; i < NWORDS; i++)
                if (int'(w_ar_idx) == i) w_rd_data = r_shadow[i*32 +: 32];
        end else if (w_ar_idx == CTRL_IDX) begin
            w_rd_data[CTRL_SER_EN_BIT] = r_ser_en;
        end else if (w_ar_idx == STATUS_IDX) begin
            w_rd_data[31:16]              = r_count;
            w_rd_data[STATUS_OVERRUN_BIT] = r_overrun;
            w_rd_data[STATUS_BUSY_BIT]    = w_busy;
        end else if (w_ar_idx == DIV_IDX) begin
            w_rd_data[15:0] = r_div;
        end else begin
            w_rd_resp = RESP_SLVERR;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_rd_acc) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (r_rvalid && s_axi.S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    frame_serializer #(.FRAME_WIDTH(FRAME_WIDTH)) u_ser (
        .i_clk       (S_AXI_ACLK),
        .i_rst_n     (S_AXI_ARESETN),
        .i_load      (w_commit & w_ser_en_next),
        .i_frame     (r_shadow),
        .i_div       (r_div),
        .o_ser_data  (ser_data),
        .o_ser_valid (ser_valid),
        .o_ser_done  (ser_done),
        .o_busy      (w_busy),
        .o_state     (w_ser_state)
    );

    assign s_axi.S_AXI_AWREADY = w_wr_acc;
    assign s_axi.S_AXI_WREADY  = w_wr_acc;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_ARREADY = w_rd_acc;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = r_rresp;
    assign frame_out           = r_active;
    assign frame_valid         = r_frame_valid;

    assign w_unused = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_single_frame_drive.sv
// Bench for single_frame_drive: AXI writes/reads, commit, serial stream, overrun, reset abort.
module tb_single_frame_drive;
  import single_frame_drive_pkg::*;

  localparam int FW = 256;
  localparam int NW = FW / 32;
  localparam int LIMIT = 100;

  logic clk;
  logic rst_n;
  logic [FW-1:0] frame_out;
  logic frame_valid, ser_data, ser_valid, ser_done;

  single_frame_drive_if axi();

  single_frame_drive #(.FRAME_WIDTH(FW)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (axi),
    .frame_out     (frame_out),
    .frame_valid   (frame_valid),
    .ser_data      (ser_data),
    .ser_valid     (ser_valid),
    .ser_done      (ser_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // serial / pulse monitor (only this block writes these)
  logic ser_bits[$];
  int sv_cnt = 0;
  int done_cnt = 0;
  int fv_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ser_valid) begin
        ser_bits.push_back(ser_data);
        sv_cnt++;
      end
      if (ser_done) done_cnt++;
      if (frame_valid) fv_cnt++;
    end
  end

  logic fv_t1;
  logic [31:0] fo0_t1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks: called and return at posedge+#1
  task automatic axi_write(input logic [10:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
    int n;
    axi.S_AXI_AWADDR  = addr;
    axi.S_AXI_WDATA   = data;
    axi.S_AXI_WSTRB   = strb;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    axi.S_AXI_BREADY  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi.S_AXI_AWREADY && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) check_eq("wr_accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    @(negedge clk);
    fv_t1  = frame_valid;
    fo0_t1 = frame_out[31:0];
    n = 0;
    while (!axi.S_AXI_BVALID && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) check_eq("bvalid_timeout", 32'd1, 32'd0);
    check_eq("bresp", 32'(axi.S_AXI_BRESP), 32'(exp_resp));
    @(posedge clk); #1;
    axi.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [10:0] addr,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n;
    logic [31:0] e;
    exp_q.push_back(exp_data);
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    axi.S_AXI_RREADY  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi.S_AXI_ARREADY && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) check_eq("ar_accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    axi.S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    n = 0;
    while (!axi.S_AXI_RVALID && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    if (n >= LIMIT) check_eq("rvalid_timeout", 32'd1, 32'd0);
    else begin
      check_eq(tag, axi.S_AXI_RDATA, e);
      check_eq({tag, "_rresp"}, 32'(axi.S_AXI_RRESP), 32'(exp_resp));
    end
    @(posedge clk); #1;
    axi.S_AXI_RREADY = 1'b0;
  endtask

  task automatic wait_cycles(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_w[NW];
  int bit_base, sv_base, done_base, fv_base, glitches, n;
  logic [31:0] rec;

  initial begin
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b0;
    rst_n = 1'b0;
    #23;
    check_eq("rst_frame_lo", frame_out[31:0], 32'd0);
    check_eq("rst_frame_hi", frame_out[255:224], 32'd0);
    check_eq("rst_outs", {27'd0, frame_valid, ser_data, ser_valid, ser_done, axi.S_AXI_BVALID}, 32'd0);
    check_eq("rst_rvalid", 32'(axi.S_AXI_RVALID), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // shadow fill and read-back; frame_out must not move
    for (int i = 0; i < NW; i++) begin
      exp_w[i] = 32'h11111111 * 32'(i + 1);
      axi_write(11'(i * 4), exp_w[i], 4'hF, RESP_OKAY);
    end
    for (int i = 0; i < NW; i++) axi_read("frame_rd", 11'(i * 4), exp_w[i], RESP_OKAY);
    check_eq("fo_precommit_lo", frame_out[31:0], 32'd0);
    check_eq("fo_precommit_hi", frame_out[255:224], 32'd0);

    // plain commit
    fv_base = fv_cnt;
    axi_write(11'h7F0, 32'h1, 4'hF, RESP_OKAY);
    check_eq("commit_fv_t1", 32'(fv_t1), 32'd1);
    check_eq("commit_fo_t1", fo0_t1, 32'h11111111);
    check_eq("commit_fo_hi", frame_out[255:224], 32'h88888888);
    wait_cycles(3);
    check_eq("commit_fv_once", 32'(fv_cnt - fv_base), 32'd1);
    check_eq("commit_ser_idle", 32'(ser_valid), 32'd0);
    axi_read("status_c1", 11'h7F4, 32'h00010000, RESP_OKAY);

    // serial commit with DIV=2
    axi_write(11'h7F8, 32'd2, 4'hF, RESP_OKAY);
    axi_write(11'h000, 32'h5, 4'hF, RESP_OKAY);
    exp_w[0] = 32'h5;
    bit_base = ser_bits.size();
    sv_base = sv_cnt;
    done_base = done_cnt;
    axi_write(11'h7F0, 32'h3, 4'hF, RESP_OKAY);
    check_eq("ser_fv_t1", 32'(fv_t1), 32'd1);
    check_eq("ser_fo_t1", fo0_t1, 32'h5);

    // disturbances during SHIFT: shadow rewrite, dropped commit, DIV change
    axi_write(11'h000, 32'hDEAD0000, 4'hF, RESP_OKAY);
    axi_write(11'h7F0, 32'h1, 4'hF, RESP_OKAY);
    check_eq("ovr_no_fv", 32'(fv_t1), 32'd0);
    check_eq("ovr_fo_kept", frame_out[31:0], 32'h5);
    axi_write(11'h7F8, 32'd7, 4'hF, RESP_OKAY);
    axi_read("status_busy_ovr", 11'h7F4, 32'h00020003, RESP_OKAY);

    n = 0;
    while (done_cnt == done_base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check_eq("ser_done_timeout", 32'd1, 32'd0);
    wait_cycles(4);
    check_eq("ser_valid_len", 32'(sv_cnt - sv_base), 32'(FW * 3));
    check_eq("ser_done_once", 32'(done_cnt - done_base), 32'd1);
    glitches = 0;
    for (int i = 0; i < FW; i++)
      if (ser_bits[bit_base + 3*i] !== ser_bits[bit_base + 3*i + 1] ||
          ser_bits[bit_base + 3*i] !== ser_bits[bit_base + 3*i + 2]) glitches++;
    check_eq("ser_bit_hold", 32'(glitches), 32'd0);
    for (int w = 0; w < NW; w++) begin
      rec = '0;
      for (int j = 0; j < 32; j++) rec[j] = ser_bits[bit_base + (32*w + j)*3 + 1];
      check_eq("ser_word", rec, exp_w[w]);
    end
    check_eq("fo_after_ser", frame_out[31:0], 32'h5);
    axi_read("status_idle_ovr", 11'h7F4, 32'h00020002, RESP_OKAY);
    axi_write(11'h7F4, 32'h2, 4'hF, RESP_OKAY);
    axi_read("status_w1c", 11'h7F4, 32'h00020000, RESP_OKAY);
    axi_read("div_rd", 11'h7F8, 32'd7, RESP_OKAY);

    // byte strobes and unmapped access
    axi_write(11'h000, 32'h0, 4'hF, RESP_OKAY);
    axi_write(11'h000, 32'hAABBCCDD, 4'b0010, RESP_OKAY);
    axi_read("wstrb_rd", 11'h000, 32'h0000CC00, RESP_OKAY);
    axi_read("unmapped_rd", 11'h7FC, 32'd0, RESP_SLVERR);
    axi_write(11'h7FC, 32'hFFFFFFFF, 4'hF, RESP_SLVERR);
    axi_read("ctrl_rd", 11'h7F0, 32'd0, RESP_OKAY);

    // reset during SHIFT with a stalled write response
    done_base = done_cnt;
    axi_write(11'h7F0, 32'h3, 4'hF, RESP_OKAY);
    check_eq("rst_pre_fo_w1", frame_out[63:32], 32'h22222222);
    wait_cycles(20);
    axi.S_AXI_AWADDR = 11'h008; axi.S_AXI_WDATA = 32'h12345678; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1; axi.S_AXI_BREADY = 1'b0;
    @(posedge clk); #1;
    axi.S_AXI_AWADDR = 11'h00C;
    @(negedge clk);
    check_eq("stall_bvalid", 32'(axi.S_AXI_BVALID), 32'd1);
    check_eq("stall_awready", 32'(axi.S_AXI_AWREADY), 32'd0);
    check_eq("pre_rst_ser_valid", 32'(ser_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_fo_lo", frame_out[31:0], 32'd0);
    check_eq("arst_fo_w1", frame_out[63:32], 32'd0);
    check_eq("arst_outs", {27'd0, frame_valid, ser_data, ser_valid, ser_done, axi.S_AXI_BVALID}, 32'd0);
    check_eq("arst_awready", 32'(axi.S_AXI_AWREADY), 32'd0);
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
    axi_read("post_rst_w0", 11'h000, 32'd0, RESP_OKAY);
    axi_read("post_rst_w2", 11'h008, 32'd0, RESP_OKAY);
    axi_read("post_rst_status", 11'h7F4, 32'd0, RESP_OKAY);
    axi_read("post_rst_div", 11'h7F8, 32'd0, RESP_OKAY);
    wait_cycles(10);
    check_eq("post_rst_no_done", 32'(done_cnt - done_base), 32'd0);
    check_eq("post_rst_ser_valid", 32'(ser_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
